// File: rtl/spi_pkg.sv
// Shared constants for the SPI flash path: FSM encoding, default word width
// and SPI mode settings used by both this shifter and the command sequencer.
package spi_pkg;

    typedef logic [1:0] spi_state_t;

    localparam spi_state_t IDLE  = 2'd0;
    localparam spi_state_t LEAD  = 2'd1;
    localparam spi_state_t SHIFT = 2'd2;
    localparam spi_state_t TRAIL = 2'd3;

    localparam int DATA_W_DEF = 8;

    // Mode 0: SCK idles low, data sampled on the rising edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 master shift engine driven by the divider's half-period strobe.
// Define SPI_LSB_FIRST_EN to shift bit 0 first in both directions.
module spi_byte_shifter
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              sck_tick,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              spi_sck,
    output logic              spi_cs_n,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    spi_state_t        state, state_nxt;
    logic              sck_q, sck_nxt;
    logic              cs_n_q, cs_n_nxt;
    logic              mosi_q, mosi_nxt;
    logic              busy_q, busy_nxt;
    logic              done_q, done_nxt;
    logic [DATA_W-1:0] rx_data_q, rx_data_nxt;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_nxt;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_nxt;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_nxt;

    // tx_shift holds only the bits not yet presented on MOSI.
    logic              tx_first;
    logic [DATA_W-1:0] tx_load;
    logic              tx_next;
    logic [DATA_W-1:0] tx_shifted;
    logic [DATA_W-1:0] rx_shifted;

`ifdef SPI_LSB_FIRST_EN
    assign tx_first   = tx_data[0];
    assign tx_load    = {1'b0, tx_data[DATA_W-1:1]};
    assign tx_next    = tx_shift_q[0];
    assign tx_shifted = {1'b0, tx_shift_q[DATA_W-1:1]};
    assign rx_shifted = {spi_miso, rx_shift_q[DATA_W-1:1]};
`else
    assign tx_first   = tx_data[DATA_W-1];
    assign tx_load    = {tx_data[DATA_W-2:0], 1'b0};
    assign tx_next    = tx_shift_q[DATA_W-1];
    assign tx_shifted = {tx_shift_q[DATA_W-2:0], 1'b0};
    assign rx_shifted = {rx_shift_q[DATA_W-2:0], spi_miso};
`endif

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: assign a default before the case so no path leaves the
        // signal unassigned, which would infer a latch.
        state_nxt = state;
        case (state)
            IDLE:    if (start && !busy_q) state_nxt = LEAD;
            LEAD:    if (sck_tick) state_nxt = SHIFT;
            SHIFT:   if (sck_tick && sck_q && bit_cnt_q == LAST_BIT) state_nxt = TRAIL;
            TRAIL:   if (sck_tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sck_nxt      = sck_q;
        cs_n_nxt     = cs_n_q;
        mosi_nxt     = mosi_q;
        busy_nxt     = busy_q;
        done_nxt     = 1'b0;
        rx_data_nxt  = rx_data_q;
        tx_shift_nxt = tx_shift_q;
        rx_shift_nxt = rx_shift_q;
        bit_cnt_nxt  = bit_cnt_q;
        case (state)
            IDLE: begin
                if (start && !busy_q) begin
                    tx_shift_nxt = tx_load;
                    cs_n_nxt     = 1'b0;
                    mosi_nxt     = tx_first;
                    busy_nxt     = 1'b1;
                    bit_cnt_nxt  = '0;
                end
            end
            SHIFT: begin
                if (sck_tick) begin
                    sck_nxt = ~sck_q;
                    if (!sck_q) begin
                        rx_shift_nxt = rx_shifted;
                    end else if (bit_cnt_q != LAST_BIT) begin
                        bit_cnt_nxt  = bit_cnt_q + 1'b1;
                        mosi_nxt     = tx_next;
                        tx_shift_nxt = tx_shifted;
                    end
                end
            end
            TRAIL: begin
                if (sck_tick) begin
                    cs_n_nxt    = 1'b1;
                    rx_data_nxt = rx_shift_q;
                    done_nxt    = 1'b1;
                    busy_nxt    = 1'b0;
                    mosi_nxt    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sck_q      <= SPI_CPOL;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_data_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            sck_q      <= sck_nxt;
            cs_n_q     <= cs_n_nxt;
            mosi_q     <= mosi_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
            rx_data_q  <= rx_data_nxt;
            tx_shift_q <= tx_shift_nxt;
            rx_shift_q <= rx_shift_nxt;
            bit_cnt_q  <= bit_cnt_nxt;
        end
    end

    assign spi_sck  = sck_q;
    assign spi_cs_n = cs_n_q;
    assign spi_mosi = mosi_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_byte_shifter.sv
// Directed self-checking bench for spi_byte_shifter with a bus monitor and a
// simple SPI slave model (loopback or fixed MISO word).
module tb_spi_byte_shifter;

    logic       clk_in;
    logic       rst;
    logic       sck_tick;
    logic       start;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       spi_sck;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;

    int compared   = 0;
    int mismatched = 0;

    logic       loopback;
    logic [7:0] miso_word;
    logic [7:0] mosi_cap;
    int         tick_cnt, rise_cnt, done_cnt, xfer_cnt;
    int         gap_run, last_gap, mosi_zero_cnt;
    logic       prev_sck, prev_cs;

    spi_byte_shifter #(.DATA_W(8)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .sck_tick (sck_tick),
        .start    (start),
        .tx_data  (tx_data),
        .busy     (busy),
        .done     (done),
        .rx_data  (rx_data),
        .spi_sck  (spi_sck),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Half-period strobe every second cycle.
    initial begin
        sck_tick = 1'b0;
        forever begin
            @(posedge clk_in);
            #1;
            sck_tick = ~sck_tick;
        end
    end

    // Bus monitor plus slave model; everything sampled on the falling clock edge.
    initial begin
        spi_miso = 1'b0;
        prev_sck = 1'b0;
        prev_cs  = 1'b1;
        mosi_cap = '0;
        tick_cnt = 0; rise_cnt = 0; done_cnt = 0; xfer_cnt = 0;
        gap_run = 0; last_gap = 0; mosi_zero_cnt = 0;
        forever begin
            @(negedge clk_in);
            if (prev_cs && !spi_cs_n) begin
                xfer_cnt++;
                last_gap      = gap_run;
                tick_cnt      = 0;
                rise_cnt      = 0;
                mosi_cap      = '0;
                mosi_zero_cnt = 0;
            end
            if (spi_cs_n) gap_run++;
            else          gap_run = 0;
            if (!spi_cs_n && sck_tick)  tick_cnt++;
            if (!spi_cs_n && !spi_mosi) mosi_zero_cnt++;
            if (!prev_sck && spi_sck) begin
                mosi_cap = {mosi_cap[6:0], spi_mosi};
                rise_cnt++;
            end
            if (done) done_cnt++;
            prev_sck = spi_sck;
            prev_cs  = spi_cs_n;
            if (loopback)          spi_miso = spi_mosi;
            else if (rise_cnt < 8) spi_miso = miso_word[3'(7 - rise_cnt)];
            else                   spi_miso = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // MOSI bit order as seen on the wire, packed first-bit-in-MSB.
    function automatic logic [7:0] wire_order(input logic [7:0] d);
        logic [7:0] r;
`ifdef SPI_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
`else
        r = d;
`endif
        return r;
    endfunction

    task automatic pulse_start(input logic [7:0] d);
        @(negedge clk_in);
        start   = 1'b1;
        tx_data = d;
        @(negedge clk_in);
        start   = 1'b0;
    endtask

    // Returns on the falling edge inside the done cycle.
    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (done !== 1'b1 && n < 200);
        check(tag, done, 1);
    endtask

    initial begin
        int base_done, base_xfer, n;
        rst = 1'b1; start = 1'b0; tx_data = '0;
        loopback = 1'b1; miso_word = '0;
        repeat (3) @(negedge clk_in);
        check("rst_cs_n", spi_cs_n, 1);
        check("rst_sck", spi_sck, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rx_data", rx_data, 0);
        rst = 1'b0;

        // Basic loopback transfer.
        base_done = done_cnt;
        pulse_start(8'hA5);
        check("basic_busy", busy, 1);
        check("basic_cs_low", spi_cs_n, 0);
        wait_done("basic_done_seen");
        check("basic_busy_in_done", busy, 0);
        #1;
        check("basic_rx", rx_data, 8'hA5);
        check("basic_mosi", mosi_cap, wire_order(8'hA5));
        check("basic_ticks", tick_cnt, 18);
        check("basic_rises", rise_cnt, 8);
        check("basic_done_once", done_cnt - base_done, 1);

        // Independent MISO pattern with all-ones MOSI.
        loopback = 1'b0; miso_word = 8'h3C;
        pulse_start(8'hFF);
        wait_done("miso_done_seen");
        #1;
        check("miso_rx", rx_data, 8'h3C);
        check("miso_mosi", mosi_cap, 8'hFF);
        check("miso_mosi_held", mosi_zero_cnt, 0);
        loopback = 1'b1;

        // Second start while busy must be ignored.
        base_done = done_cnt; base_xfer = xfer_cnt;
        pulse_start(8'h11);
        repeat (3) @(negedge clk_in);
        pulse_start(8'h22);
        wait_done("busy_done_seen");
        #1;
        check("busy_mosi", mosi_cap, wire_order(8'h11));
        check("busy_rx", rx_data, 8'h11);
        repeat (60) @(negedge clk_in);
        check("busy_one_xfer", xfer_cnt - base_xfer, 1);
        check("busy_one_done", done_cnt - base_done, 1);

        // Back-to-back: start asserted in the done cycle.
        pulse_start(8'hC3);
        wait_done("b2b_first_done");
        start = 1'b1; tx_data = 8'h5A;
        #1;
        check("b2b_first_rx", rx_data, 8'hC3);
        @(negedge clk_in);
        start = 1'b0;
        check("b2b_busy", busy, 1);
        wait_done("b2b_second_done");
        #1;
        check("b2b_cs_gap", last_gap, 1);
        check("b2b_mosi", mosi_cap, wire_order(8'h5A));
        check("b2b_rx", rx_data, 8'h5A);

        // Reset after seven ticks of a transfer.
        base_done = done_cnt;
        pulse_start(8'h96);
        n = 0;
        while (tick_cnt != 7 && n < 200) begin
            @(posedge clk_in);
            #2;
            n++;
        end
        check("mid_rst_tick7", tick_cnt, 7);
        check("mid_rst_busy_before", busy, 1);
        rst = 1'b1;
        @(posedge clk_in);
        #1;
        check("mid_rst_cs_n", spi_cs_n, 1);
        check("mid_rst_sck", spi_sck, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rx", rx_data, 0);
        check("mid_rst_mosi", spi_mosi, 0);
        @(negedge clk_in);
        rst = 1'b0;
        repeat (60) @(negedge clk_in);
        check("mid_rst_no_done", done_cnt - base_done, 0);

        // Bit-order probe: first MOSI bit reveals MSB- vs LSB-first.
        pulse_start(8'h01);
        wait_done("order_done_seen");
        #1;
        check("order_mosi", mosi_cap, wire_order(8'h01));
`ifdef SPI_LSB_FIRST_EN
        check("order_first_bit", mosi_cap[7], 1);
`else
        check("order_first_bit", mosi_cap[7], 0);
`endif
        check("order_rx", rx_data, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spi_byte_shifter.md
Name: spi_byte_shifter

Overview:
- SPI mode-0 master shift engine for the APB-to-SPI-NOR flash path.
- Sits directly downstream of the clock-divider stage. It consumes that stage's half-period strobe (sck_tick) and produces SCK, CS_n and MOSI, and samples MISO.
- Runs entirely in the fast system clock domain. SCK is a registered output, never a clock.
- Upstream command logic hands it one word per start/done handshake.

Parameters:
- DATA_W, 8, bits per transfer; legal range >= 2.

Ports:
- clk_in  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- sck_tick  input  1  single-cycle strobe from the divider stage, one per SCK half-period.
- start  input  1  transfer request; honoured only when busy=0.
- tx_data  input  DATA_W  word to send, captured on the accepted start cycle.
- busy  output  1  high from the cycle after start is accepted until the done cycle.
- done  output  1  one-cycle pulse; rx_data is valid from this cycle.
- rx_data  output  DATA_W  last received word; holds until the next done.
- spi_sck  output  1  serial clock, idle low (CPOL=0).
- spi_cs_n  output  1  chip select, active low.
- spi_mosi  output  1  serial data out.
- spi_miso  input  1  serial data in; assumed already synchronised by the pad stage.

Behaviour:
- Reset is synchronous; rst has priority over every other input.
- Reset values: state=IDLE, spi_sck=0, spi_cs_n=1, spi_mosi=0, busy=0, done=0, rx_data=0, shift registers=0, bit_cnt=0.
- States: IDLE, LEAD, SHIFT, TRAIL.
- IDLE:
  - start=1 and busy=0 -> load tx_data into tx_shift.
  - Same edge: spi_cs_n<=0, spi_mosi<=first bit (MSB), busy<=1, bit_cnt<=0, next state LEAD.
  - A sck_tick in the start cycle is not consumed.
- LEAD: on the first sck_tick -> SHIFT. spi_sck stays 0. This gives CS setup of one half-period.
- SHIFT: each sck_tick toggles spi_sck.
  - Rising tick (spi_sck 0->1): rx_shift <= {rx_shift[DATA_W-2:0], spi_miso}.
  - Falling tick (1->0), bit_cnt==DATA_W-1: next state TRAIL; spi_mosi holds.
  - Falling tick (1->0), otherwise: bit_cnt++ and spi_mosi <= next bit.
- TRAIL: on the next sck_tick:
  - spi_cs_n<=1, rx_data<=rx_shift, done<=1 for one cycle, busy<=0, spi_mosi<=0.
  - Next state IDLE.
- Transfer length: exactly 2*DATA_W+2 sck_ticks from LEAD entry to done. MOSI is stable one half-period either side of each rising edge.
- start while busy=1: ignored; tx_data is not re-sampled.
- start in the done cycle (busy=0): accepted. Back-to-back transfers are legal; CS deasserts for at least one clk_in cycle between them.
- sck_tick stuck low: block waits indefinitely in the current state and holds all outputs.
- rst mid-transfer: all reset values apply at the next edge. No done, rx_data cleared, CS released immediately.
- bit_cnt width: $clog2(DATA_W). No wrap occurs because SHIFT exits at DATA_W-1.

Optional Feature:
- Macro SPI_LSB_FIRST_EN.
- Defined: tx shifts out bit 0 first, and rx shifts in from the MSB end, so rx_data[0] is the first bit received.
- Undefined (default): MSB first on both directions, as described above.
- Ports and timing are identical in both cases.

Decomposition:
- Package spi_pkg holds:
  - the state encoding (2-bit localparams IDLE/LEAD/SHIFT/TRAIL);
  - the default DATA_W value;
  - the SPI mode constants (CPOL=0, CPHA=0) shared with the command sequencer.
- No sub-module. Tick generation stays in the existing divider stage, and the FSM plus shift registers form one cohesive block.

Test Plan:
- Basic transfer: sck_tick every 2 cycles, tx_data=8'hA5, MISO loopback from MOSI -> MOSI bits 1,0,1,0,0,1,0,1 on 8 rising edges; done once; rx_data=8'hA5; 18 ticks from LEAD entry to done.
- MISO pattern: MISO driven 8'h3C independently, tx_data=8'hFF -> rx_data=8'h3C; MOSI held high for the whole transfer.
- Busy rejection: start with tx_data=8'h11, then start with tx_data=8'h22 while busy -> only one transfer occurs, with MOSI carrying 8'h11.
- Back-to-back: start asserted in the done cycle with tx_data=8'h5A -> CS high for exactly 1 cycle, second transfer shifts 8'h5A.
- Mid-transfer reset: rst asserted after 7 ticks -> next edge gives cs_n=1, sck=0, busy=0, rx_data=0, and done never pulses.
- With SPI_LSB_FIRST_EN defined, tx_data=8'h01, MISO loopback -> first MOSI bit is 1, rx_data=8'h01.
